// File: rtl/rr_mux_wide.sv
// rr_mux_wide: registered CHANNELS:1 wide multiplexer with valid/ready
// handshaking and round-robin arbitration. Each output word is tagged with
// the index of the channel that supplied it.
//
// Build option: define RR_MUX_ZERO_IDLE_EN to force out/out_sel to zero
// whenever the output register is (or becomes) empty. Without it the last
// accepted word stays on out/out_sel while idle. Handshake and arbitration
// behaviour are identical in both builds.
module rr_mux_wide #(
  parameter int WIDTH    = 64,
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    in [0:CHANNELS-1],
  input  logic [CHANNELS-1:0] in_valid,
  output logic [CHANNELS-1:0] in_ready,
  output logic [WIDTH-1:0]    out,
  output logic [SELW-1:0]     out_sel,
  output logic                out_valid,
  input  logic                out_ready
);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] winner;
  logic [SELW-1:0] ptr_next;
  logic            found;
  logic            free;
  logic            accept;

  // Channel index base+off folded back into 0..CHANNELS-1 (off < CHANNELS).
  function automatic logic [SELW-1:0] wrap_idx(input logic [SELW-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = {{(32-SELW){1'b0}}, base} + off;
    if (s >= CHANNELS) s = s - CHANNELS;
    return SELW'(s);
  endfunction

  assign free   = !out_valid || out_ready;
  assign accept = found && free && !reset;

  // Round-robin scan starting at ptr; first valid channel wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (!found && in_valid[wrap_idx(ptr, k)]) begin
        found  = 1'b1;
        winner = wrap_idx(ptr, k);
      end
    end
  end

  // One-hot accept strobe back to the winning producer.
  always_comb begin
    in_ready = '0;
    if (accept) in_ready[winner] = 1'b1;
  end

  // Pointer advances past the winner, wrapping at the last channel.
  always_comb begin
    ptr_next = winner + 1'b1;
    if (winner == SELW'(CHANNELS - 1)) ptr_next = '0;
  end

  // Output register and arbitration pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (accept) begin
      out       <= in[winner];
      out_sel   <= winner;
      out_valid <= 1'b1;
      ptr       <= ptr_next;
    end else if (free) begin
      // Register empty or just consumed with nothing new to load.
      out_valid <= 1'b0;
`ifdef RR_MUX_ZERO_IDLE_EN
      out       <= '0;
      out_sel   <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_rr_mux_wide.sv
// Directed, table-driven bench for rr_mux_wide (WIDTH=64, CHANNELS=4).
module tb_rr_mux_wide;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] din [0:3];
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [63:0] out;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_mux_wide #(.WIDTH(64), .CHANNELS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (din),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  typedef struct {
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle: check combinational in_ready before the edge, then the
  // registered outputs just after it.
  task automatic cyc(input logic [3:0] v, input logic r, input logic [3:0] er,
                     input logic eov, input logic [1:0] es, input logic [63:0] eo,
                     input bit cdata);
    in_valid  = v;
    out_ready = r;
    #1;
    chk("in_ready", {60'd0, in_ready}, {60'd0, er});
    @(posedge clk);
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, eov});
    if (cdata) begin
      chk("out_sel", {62'd0, out_sel}, {62'd0, es});
      chk("out", out, eo);
    end
  endtask

  logic [63:0] idle_exp;

  initial begin
    for (int i = 0; i < 4; i++) din[i] = 64'hA0 + 64'(i);

    // rotation with all channels valid
    tbl[0]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[1]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[5]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[6]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[7]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd3};
    // skip: only channels 1 and 3
    tbl[8]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[9]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[10] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[11] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
    // wrap: only channel 0, then ptr should sit at 1
    tbl[12] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[13] = '{4'hF,    1'b1, 4'b0010, 1'b1, 2'd1};
    // no valid inputs: pointer holds at 2
    tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[15] = '{4'hF,    1'b1, 4'b0100, 1'b1, 2'd2};

    // Reset held for two cycles with every channel offering.
    reset = 1'b1;
    cyc(4'hF, 1'b0, 4'b0000, 1'b0, 2'd0, 64'd0, 1'b1);
    cyc(4'hF, 1'b0, 4'b0000, 1'b0, 2'd0, 64'd0, 1'b1);
    reset = 1'b0;

    for (int i = 0; i < 16; i++)
      cyc(tbl[i].vld, tbl[i].ordy, tbl[i].exp_rdy, tbl[i].exp_ov, tbl[i].exp_sel,
          64'hA0 + 64'(tbl[i].exp_sel), tbl[i].exp_ov);

    // Backpressure: load channel 2 word (ptr=3 scans 3,0,1,2), then stall.
    din[2] = 64'hDEADBEEF_00000002;
    cyc(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 64'hDEADBEEF_00000002, 1'b1);
    for (int i = 0; i < 5; i++)
      cyc(4'hF, 1'b0, 4'b0000, 1'b1, 2'd2, 64'hDEADBEEF_00000002, 1'b1);
    // Release: consume and accept channel 3 on the same edge.
    cyc(4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 64'hA3, 1'b1);
    din[2] = 64'hA2;

    // Reset mid-stream: hold a distinctive channel-0 word, ptr=1.
    din[0] = 64'h5555;
    cyc(4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 64'h5555, 1'b1);
    din[0] = 64'hA0;
    reset = 1'b1;
    cyc(4'hF, 1'b0, 4'b0000, 1'b0, 2'd0, 64'd0, 1'b1);
    reset = 1'b0;
    // Arbitration restarts at channel 0.
    cyc(4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 64'hA0, 1'b1);

    // Idle value after a single accept of 64'h1234 (ptr=1 scans to 0).
    din[0] = 64'h1234;
    cyc(4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 64'h1234, 1'b1);
`ifdef RR_MUX_ZERO_IDLE_EN
    idle_exp = 64'd0;
`else
    idle_exp = 64'h1234;
`endif
    cyc(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, idle_exp, 1'b1);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, idle_exp, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
